// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial packed-BCD adder.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int         DIGW     = 4;
    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_CORR = 4'd6;

endpackage

// File: rtl/bcd_serial_add_ctrl_if.sv
// Operand/result bundle between an operand source and the serial BCD adder.
interface bcd_serial_add_ctrl_if #(
    parameter int NDIG = 4
);
    import bcd_pkg::*;

    logic                 start;
    logic [DIGW*NDIG-1:0] A;
    logic [DIGW*NDIG-1:0] B;
    logic                 Ci;
    logic                 busy;
    logic                 done;
    logic [DIGW*NDIG-1:0] S;
    logic                 Co;
    logic                 err;

    modport master (
        output start, A, B, Ci,
        input  busy, done, S, Co, err
    );

    modport slave (
        input  start, A, B, Ci,
        output busy, done, S, Co, err
    );

endinterface

// File: rtl/bcd_digit_add.sv
// Single-digit decimal adder; carry out is the >9 correction condition itself.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [DIGW-1:0] a,
    input  logic [DIGW-1:0] b,
    input  logic            ci,
    output logic [DIGW-1:0] s,
    output logic            co
);

    logic [DIGW:0] z_s;

    // Binary sum, then decimal correction when the raw digit leaves 0..9.
    always_comb begin
        z_s = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
        if (z_s > {1'b0, BCD_MAX}) begin
            s  = z_s[DIGW-1:0] + BCD_CORR;
            co = 1'b1;
        end else begin
            s  = z_s[DIGW-1:0];
            co = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Multi-digit packed-BCD adder that reuses one digit adder, LSD first, one digit per clock.
module bcd_serial_add_ctrl
    import bcd_pkg::*;
#(
    parameter int NDIG = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    bcd_serial_add_ctrl_if.slave        bus
);

    localparam int W    = DIGW * NDIG;
    localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NDIG - 1);

    state_t          state_r;
    state_t          state_nxt_s;
    logic [W-1:0]    op_a_r;
    logic [W-1:0]    op_b_r;
    logic [W-1:0]    s_r;
    logic            carry_r;
    logic            co_r;
    logic            err_r;
    logic            busy_r;
    logic            done_r;
    logic [IDXW-1:0] idx_r;

    logic            accept_s;
    logic            last_s;
    logic [DIGW-1:0] dig_a_s;
    logic [DIGW-1:0] dig_b_s;
    logic [DIGW-1:0] dig_s_s;
    logic            dig_co_s;

    function automatic logic any_invalid(input logic [W-1:0] v);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            r = r | (v[i*DIGW +: DIGW] > BCD_MAX);
        end
        return r;
    endfunction

    // A new request is only taken when no operation is in flight.
    always_comb begin
        accept_s = bus.start && ((state_r == IDLE) || (state_r == DONE));
        last_s   = (idx_r == IDX_LAST);
        dig_a_s  = op_a_r[idx_r*DIGW +: DIGW];
        dig_b_s  = op_b_r[idx_r*DIGW +: DIGW];
    end

    bcd_digit_add u_digit (
        .a  (dig_a_s),
        .b  (dig_b_s),
        .ci (carry_r),
        .s  (dig_s_s),
        .co (dig_co_s)
    );

    // Next-state decode; DONE can chain straight back into RUN.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DONE: begin
                if (accept_s) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register with status flags registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == RUN);
            done_r  <= (state_nxt_s == DONE);
        end
    end

    // Operand latch, digit index, ripple carry and result assembly.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a_r  <= '0;
            op_b_r  <= '0;
            s_r     <= '0;
            carry_r <= 1'b0;
            co_r    <= 1'b0;
            err_r   <= 1'b0;
            idx_r   <= '0;
        end else if (accept_s) begin
            op_a_r  <= bus.A;
            op_b_r  <= bus.B;
            carry_r <= bus.Ci;
            s_r     <= '0;
            co_r    <= 1'b0;
            err_r   <= any_invalid(bus.A) | any_invalid(bus.B);
            idx_r   <= '0;
        end else if (state_r == RUN) begin
            s_r[idx_r*DIGW +: DIGW] <= dig_s_s;
            carry_r                 <= dig_co_s;
            idx_r                   <= idx_r + IDXW'(1);
            if (last_s) begin
                co_r <= dig_co_s;
            end else begin
                co_r <= co_r;
            end
        end else begin
            s_r  <= s_r;
            co_r <= co_r;
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.S    = s_r;
    assign bus.Co   = co_r;
    assign bus.err  = err_r;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Scoreboard bench: stimulus queues expected results, a negedge monitor checks each done pulse.
module tb_bcd_serial_add_ctrl;

    localparam int NDIG = 4;
    localparam int W    = 4 * NDIG;

    typedef struct {
        logic [W-1:0] s;
        logic         co;
        logic         err;
        logic         chk_s;
    } exp_t;

    logic clk;
    logic rst;
    exp_t exp_q[$];
    int   n_vec;
    int   n_err;

    bcd_serial_add_ctrl_if #(.NDIG(NDIG)) bus ();

    bcd_serial_add_ctrl #(.NDIG(NDIG)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.chk_s) chk("S", 32'(bus.S), 32'(e.s));
                chk("Co", 32'(bus.Co), 32'(e.co));
                chk("err", 32'(bus.err), 32'(e.err));
            end
        end
    end

    task automatic push_exp(input logic [W-1:0] s, input logic co, input logic err, input logic chk_s);
        exp_t e;
        e.s = s; e.co = co; e.err = err; e.chk_s = chk_s;
        exp_q.push_back(e);
    endtask

    // Issue one operation from an idle bus and check busy length and done latency.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                          input logic [W-1:0] es, input logic eco, input logic eerr, input logic chk_s);
        int busy_cnt;
        push_exp(es, eco, eerr, chk_s);
        bus.A = a; bus.B = b; bus.Ci = ci; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.A = ~a; bus.B = ~b; bus.Ci = ~ci;
        busy_cnt = 0;
        for (int k = 0; k < NDIG; k++) begin
            @(negedge clk);
            if (bus.busy === 1'b1 && bus.done === 1'b0) busy_cnt++;
        end
        chk("busy_cycles", 32'(busy_cnt), 32'(NDIG));
        @(negedge clk);
        chk("done_latency", 32'(bus.done), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        n_vec = 0; n_err = 0;
        rst = 1'b1;
        bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.Ci = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_S",    32'(bus.S),    32'd0);
        chk("rst_Co",   32'(bus.Co),   32'd0);
        chk("rst_err",  32'(bus.err),  32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 1'b1);
        run_op(16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        run_op(16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b1);
        run_op(16'h0009, 16'h0009, 1'b1, 16'h0019, 1'b0, 1'b0, 1'b1);
        run_op(16'h5000, 16'h5000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        run_op(16'h4821, 16'h3179, 1'b1, 16'h8001, 1'b0, 1'b0, 1'b1);
        run_op(16'h00A3, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        run_op(16'h0000, 16'hF000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        run_op(16'h2500, 16'h2500, 1'b0, 16'h5000, 1'b0, 1'b0, 1'b1);

        // Results hold while idle.
        repeat (3) @(posedge clk);
        #1;
        chk("hold_S",  32'(bus.S),  32'h5000);
        chk("hold_Co", 32'(bus.Co), 32'd0);

        // start held high, operands changed mid-run: second op accepted in DONE.
        push_exp(16'h6912, 1'b0, 1'b0, 1'b1);
        push_exp(16'h3333, 1'b0, 1'b0, 1'b1);
        bus.A = 16'h1234; bus.B = 16'h5678; bus.Ci = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.A = 16'h1111; bus.B = 16'h2222;
        repeat (NDIG) @(negedge clk);
        @(negedge clk);
        chk("b2b_done1", 32'(bus.done), 32'd1);
        @(posedge clk); #1;
        bus.start = 1'b0;
        cnt = 0;
        for (int k = 0; k < NDIG; k++) begin
            @(negedge clk);
            if (bus.busy === 1'b1 && bus.done === 1'b0) cnt++;
        end
        chk("b2b_busy", 32'(cnt), 32'(NDIG));
        @(negedge clk);
        chk("b2b_done2", 32'(bus.done), 32'd1);
        @(posedge clk); #1;

        // Reset in the second RUN cycle aborts the operation without a done.
        bus.A = 16'h1234; bus.B = 16'h5678; bus.Ci = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_S",    32'(bus.S),    32'd0);
        chk("abort_Co",   32'(bus.Co),   32'd0);
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.done !== 1'b0) cnt++;
        end
        chk("abort_no_done", 32'(cnt), 32'd0);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
